rice_bus_ram_slave: RTL and testbench
=====================================

RICE_BUS_RAM_SLAVE -- requirements
Module: rice_bus_ram_slave

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 64, request address width in bits.
REQ-002 Parameter DATA_WIDTH, default 64, data width in bits; STROBE_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter WORDS, default 256, storage depth in DATA_WIDTH words; power of two, at least 2.
REQ-004 Parameter BASE_ADDRESS, default 0, byte address of word 0; aligned to WORDS*STROBE_WIDTH.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  reset; synchronous, active-low.
REQ-007 o_request_ready  output  1  slave can accept a request this cycle.
REQ-008 i_request_valid  input  1  master presents a request.
REQ-009 i_write  input  1  1 = write, 0 = read.
REQ-010 i_address  input  ADDRESS_WIDTH  byte address.
REQ-011 i_strobe  input  STROBE_WIDTH  byte enables for writes; ignored for reads.
REQ-012 i_write_data  input  DATA_WIDTH  write data.
REQ-013 i_response_ready  input  1  master can accept a response this cycle.
REQ-014 o_response_valid  output  1  response present.
REQ-015 o_read_data  output  DATA_WIDTH  read data; 0 for writes and errored requests.
REQ-016 o_error  output  1  request was rejected (decode or alignment error).

Function
REQ-017 A request SHALL be accepted in any cycle where i_request_valid and o_request_ready are both 1; at most one per cycle.
REQ-018 Word index SHALL be (i_address - BASE_ADDRESS) >> log2(STROBE_WIDTH), truncated to log2(WORDS) bits.
REQ-019 The error condition SHALL be: address below BASE_ADDRESS, address at or above BASE_ADDRESS + WORDS*STROBE_WIDTH, or any nonzero low log2(STROBE_WIDTH) address bits.
REQ-020 An accepted error-free write SHALL update only the bytes of the indexed word whose strobe bit is 1, at the accepting edge.
REQ-021 An errored write SHALL leave storage unchanged.
REQ-022 An accepted read SHALL return the indexed word as it stands after all previously accepted writes (read-after-write in consecutive cycles returns new data).
REQ-023 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-024 Responses SHALL be held in a 2-entry response queue (states EMPTY, ONE, FULL).
REQ-025 Queue transitions: push only raises occupancy by 1; pop only (o_response_valid and i_response_ready) lowers it by 1; simultaneous push and pop leaves occupancy unchanged.
REQ-026 A response SHALL be visible on o_response_valid no earlier than the cycle after its request is accepted; minimum latency is 1 cycle.
REQ-027 o_request_ready SHALL be 1 exactly when the queue is not FULL, derived from registered state only, with no combinational path from i_response_ready.
REQ-028 o_response_valid, o_read_data and o_error SHALL hold stable while o_response_valid is 1 and i_response_ready is 0.
REQ-029 When o_response_valid is 0, o_read_data and o_error SHALL be 0.
REQ-030 Sustained throughput SHALL be one request per cycle while i_response_ready stays 1.

Reset
REQ-031 While i_rst_n is 0 at a rising edge: queue SHALL go to EMPTY, o_response_valid 0, o_error 0, o_read_data 0, o_request_ready 1 from the next cycle.
REQ-032 Reset asserted mid-operation SHALL discard all queued responses and ignore any request presented in that cycle, including its write.
REQ-033 Storage contents SHALL NOT be reset.

Structure
REQ-034 Width constants and a response struct {read_data, error} SHALL live in shared package rice_bus_pkg.
REQ-035 The response queue SHALL be sub-module rice_bus_response_fifo (depth 2, parameterised by payload type).

Verification
REQ-036 Write 0x1122334455667788 strobe 0xFF to BASE+0x08, then read 0x08 -> write response error 0 data 0; read data 0x1122334455667788.
REQ-037 Write 0xAAAA...AA strobe 0x0F to 0x08 over prior data, then read -> 0x11223344AAAAAAAA.
REQ-038 Read at 0x0C (misaligned) and at BASE+WORDS*8 -> o_error 1, o_read_data 0; subsequent read of 0x08 is unchanged.
REQ-039 Hold i_response_ready 0 and issue 3 back-to-back reads -> 2 accepted, o_request_ready 0 from the cycle after the 2nd acceptance; release -> responses returned in order, 3rd request accepted.
REQ-040 Back-to-back requests with i_response_ready 1 -> one acceptance and one response per cycle, latency 1.
REQ-041 Assert i_rst_n 0 with FULL queue plus a pending write -> o_response_valid 0 next cycle, write not applied.

Source files
------------

// File: rtl/rice_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rice_bus_pkg
// Description : Shared width constants and response payload for the rice bus.
// Revision    : 1.0 - initial release
// ============================================================================
package rice_bus_pkg;

  localparam int c_ADDRESS_WIDTH = 64;
  localparam int c_DATA_WIDTH    = 64;
  localparam int c_STROBE_WIDTH  = c_DATA_WIDTH / 8;

  // Payload is sized to the bus-wide data width; narrower slaves zero-extend.
  typedef struct packed {
    logic [c_DATA_WIDTH-1:0] read_data;
    logic                    error;
  } response_t;

endpackage
`default_nettype wire

// File: rtl/rice_bus_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : rice_bus_ram_slave_if
// Description : Request/response handshake bundle between a master and a RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface rice_bus_ram_slave_if #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64
);

  localparam int c_STROBE_WIDTH = DATA_WIDTH / 8;

  logic                      o_request_ready;
  logic                      i_request_valid;
  logic                      i_write;
  logic [ADDRESS_WIDTH-1:0]  i_address;
  logic [c_STROBE_WIDTH-1:0] i_strobe;
  logic [DATA_WIDTH-1:0]     i_write_data;
  logic                      i_response_ready;
  logic                      o_response_valid;
  logic [DATA_WIDTH-1:0]     o_read_data;
  logic                      o_error;

  modport slave (
    output o_request_ready, o_response_valid, o_read_data, o_error,
    input  i_request_valid, i_write, i_address, i_strobe, i_write_data, i_response_ready
  );

  modport master (
    input  o_request_ready, o_response_valid, o_read_data, o_error,
    output i_request_valid, i_write, i_address, i_strobe, i_write_data, i_response_ready
  );

endinterface
`default_nettype wire

// File: rtl/rice_bus_response_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rice_bus_response_fifo
// Description : Two-entry registered response queue, payload type parameterised.
// Revision    : 1.0 - initial release
// ============================================================================
module rice_bus_response_fifo #(
  parameter type PAYLOAD_T = logic
) (
  input  wire logic i_clk,
  input  wire logic i_rst_n,
  input  wire logic i_push,
  input  PAYLOAD_T  i_data,
  output logic      o_ready,
  output logic      o_valid,
  input  wire logic i_ready,
  output PAYLOAD_T  o_data
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0] r_state;
  PAYLOAD_T   r_head;
  PAYLOAD_T   r_tail;
  logic       w_push;
  logic       w_pop;

  assign o_valid = (r_state != c_EMPTY);
  assign o_ready = (r_state != c_FULL);
  assign o_data  = o_valid ? r_head : '0;
  assign w_push  = i_push & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_push) begin
            r_head  <= i_data;
            r_state <= c_ONE;
          end
        end
        c_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_tail  <= i_data;
              r_state <= c_FULL;
            end
            2'b01:   r_state <= c_EMPTY;
            2'b11:   r_head  <= i_data;
            default: ;
          endcase
        end
        c_FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= c_ONE;
          end
        end
        default: r_state <= c_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rice_bus_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : rice_bus_ram_slave
// Description : Byte-strobed RAM slave with address decode and 2-deep response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module rice_bus_ram_slave
  import rice_bus_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = c_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH    = c_DATA_WIDTH,
  parameter int                       WORDS         = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0
) (
  input wire logic             i_clk,
  input wire logic             i_rst_n,
  rice_bus_ram_slave_if.slave  bus
);

  localparam int c_STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int c_OFFSET_BITS  = $clog2(c_STROBE_WIDTH);
  localparam int c_INDEX_BITS   = $clog2(WORDS);
  // One extra bit so the window end cannot wrap near the top of the address space.
  localparam logic [ADDRESS_WIDTH:0] c_LIMIT =
    {1'b0, BASE_ADDRESS} + (ADDRESS_WIDTH+1)'(WORDS * c_STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_ALIGN_MASK = ADDRESS_WIDTH'(c_STROBE_WIDTH - 1);

  logic [DATA_WIDTH-1:0]    r_mem [WORDS];
  logic                     w_accept;
  logic                     w_error;
  logic                     w_fifo_ready;
  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic [c_INDEX_BITS-1:0]  w_index;
  response_t                w_rsp;
  response_t                w_head;

  assign w_accept            = bus.i_request_valid & w_fifo_ready;
  assign bus.o_request_ready = w_fifo_ready;
  assign w_offset            = bus.i_address - BASE_ADDRESS;
  assign w_index             = c_INDEX_BITS'(w_offset >> c_OFFSET_BITS);
  assign w_error             = (bus.i_address < BASE_ADDRESS)
                             | ({1'b0, bus.i_address} >= c_LIMIT)
                             | ((bus.i_address & c_ALIGN_MASK) != '0);

  // Read data is captured at acceptance, so it already reflects earlier writes.
  always_comb begin
    w_rsp       = '0;
    w_rsp.error = w_error;
    if (!w_error && !bus.i_write) begin
      w_rsp.read_data = c_DATA_WIDTH'(r_mem[w_index]);
    end
  end

  // Storage is deliberately not reset; a reset cycle only suppresses the write.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_accept && bus.i_write && !w_error) begin
      for (int b = 0; b < c_STROBE_WIDTH; b++) begin
        if (bus.i_strobe[b]) begin
          r_mem[w_index][b*8 +: 8] <= bus.i_write_data[b*8 +: 8];
        end
      end
    end
  end

  rice_bus_response_fifo #(
    .PAYLOAD_T (response_t)
  ) u_response_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_accept),
    .i_data  (w_rsp),
    .o_ready (w_fifo_ready),
    .o_valid (bus.o_response_valid),
    .i_ready (bus.i_response_ready),
    .o_data  (w_head)
  );

  assign bus.o_read_data = w_head.read_data[DATA_WIDTH-1:0];
  assign bus.o_error     = w_head.error;

endmodule
`default_nettype wire

// File: tb/tb_rice_bus_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_rice_bus_ram_slave
// Description : Self-checking bench for rice_bus_ram_slave against a queue/array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rice_bus_ram_slave;

  localparam int          AW    = 64;
  localparam int          DW    = 64;
  localparam int          WORDS = 16;
  localparam logic [63:0] BASE  = 64'h1000;
  localparam logic [63:0] INIT  = 64'hC0DE_0000_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rice_bus_ram_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rice_bus_ram_slave #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .WORDS         (WORDS),
    .BASE_ADDRESS  (BASE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_s;

  logic [63:0] mdl_mem [WORDS];
  rsp_s        mdl_q[$];
  rsp_s        cap_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          rand_ready = 1'b0;
  int          cycle = 0;

  function automatic bit addr_err(input logic [63:0] a);
    return (a < BASE) || (a >= BASE + 64'(WORDS * 8)) || (a[2:0] != 3'd0);
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'(((a - BASE) >> 3) & 64'(WORDS - 1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one response per accepted request, in order; at most two outstanding.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst_n) begin
      mdl_q.delete();
    end else begin
      bit   pop;
      bit   acc;
      rsp_s r;
      pop = (mdl_q.size() > 0) && bus.i_response_ready;
      acc = bus.i_request_valid && (mdl_q.size() < 2);
      if (pop) void'(mdl_q.pop_front());
      if (acc) begin
        r.err  = addr_err(bus.i_address);
        r.data = (!r.err && !bus.i_write) ? mdl_mem[word_of(bus.i_address)] : 64'd0;
        if (!r.err && bus.i_write) begin
          for (int b = 0; b < 8; b++)
            if (bus.i_strobe[b])
              mdl_mem[word_of(bus.i_address)][8*b +: 8] = bus.i_write_data[8*b +: 8];
        end
        mdl_q.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("request_ready", 64'(bus.o_request_ready), 64'(mdl_q.size() < 2));
      chk("response_valid", 64'(bus.o_response_valid), 64'(mdl_q.size() > 0));
      chk("read_data", bus.o_read_data, (mdl_q.size() > 0) ? mdl_q[0].data : 64'd0);
      chk("error", 64'(bus.o_error), (mdl_q.size() > 0) ? 64'(mdl_q[0].err) : 64'd0);
      if (bus.o_response_valid === 1'b1 && bus.i_response_ready === 1'b1)
        cap_q.push_back('{bus.o_read_data, bus.o_error});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.i_response_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d);
    int n;
    bit done;
    bus.i_request_valid = 1'b1;
    bus.i_write         = wr;
    bus.i_address       = a;
    bus.i_strobe        = s;
    bus.i_write_data    = d;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      if (bus.o_request_ready === 1'b1) begin
        step();
        done = 1'b1;
      end else if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: request %h not accepted after %0d cycles", a, n);
        done = 1'b1;
      end else begin
        step();
        n++;
      end
    end
    bus.i_request_valid = 1'b0;
  endtask

  task automatic chk_cap(input int k, input logic [63:0] d, input logic e);
    if (cap_q.size() > k) begin
      chk($sformatf("resp%0d_data", k), cap_q[k].data, d);
      chk($sformatf("resp%0d_error", k), 64'(cap_q[k].err), 64'(e));
    end else begin
      checks++;
      errors++;
      $display("FAIL resp%0d_missing: got %0d responses, required more than %0d", k, cap_q.size(), k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.i_request_valid  = 1'b0;
    bus.i_write          = 1'b0;
    bus.i_address        = '0;
    bus.i_strobe         = '0;
    bus.i_write_data     = '0;
    bus.i_response_ready = 1'b1;
    step();
    chk_en = 1'b1;
    chk("reset_ready", 64'(bus.o_request_ready), 64'd1);
    chk("reset_valid", 64'(bus.o_response_valid), 64'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < WORDS; i++) issue(1'b1, BASE + 64'(i * 8), 8'hFF, INIT | 64'(i));
    repeat (3) step();

    cap_q.delete();
    issue(1'b1, BASE + 64'h8, 8'hFF, 64'h1122_3344_5566_7788);
    issue(1'b0, BASE + 64'h8, 8'h00, 64'd0);
    repeat (3) step();
    chk_cap(0, 64'd0, 1'b0);
    chk_cap(1, 64'h1122_3344_5566_7788, 1'b0);

    cap_q.delete();
    issue(1'b1, BASE + 64'h8, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
    issue(1'b0, BASE + 64'h8, 8'h00, 64'd0);
    repeat (3) step();
    chk_cap(0, 64'd0, 1'b0);
    chk_cap(1, 64'h1122_3344_AAAA_AAAA, 1'b0);

    cap_q.delete();
    issue(1'b0, BASE + 64'hC, 8'h00, 64'd0);
    issue(1'b0, BASE + 64'(WORDS * 8), 8'h00, 64'd0);
    issue(1'b0, BASE - 64'h8, 8'h00, 64'd0);
    issue(1'b1, BASE + 64'hC, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, BASE + 64'h8, 8'h00, 64'd0);
    repeat (3) step();
    chk_cap(0, 64'd0, 1'b1);
    chk_cap(1, 64'd0, 1'b1);
    chk_cap(2, 64'd0, 1'b1);
    chk_cap(3, 64'd0, 1'b1);
    chk_cap(4, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // Stalled responses: two accepted, third waits until the master drains.
    cap_q.delete();
    bus.i_response_ready = 1'b0;
    fork
      begin
        issue(1'b0, BASE + 64'h10, 8'h00, 64'd0);
        issue(1'b0, BASE + 64'h18, 8'h00, 64'd0);
        issue(1'b0, BASE + 64'h20, 8'h00, 64'd0);
      end
      begin
        repeat (4) step();
        chk("stall_ready", 64'(bus.o_request_ready), 64'd0);
        chk("stall_valid", 64'(bus.o_response_valid), 64'd1);
        chk("stall_head", bus.o_read_data, INIT | 64'd2);
        bus.i_response_ready = 1'b1;
      end
    join
    repeat (3) step();
    chk_cap(0, INIT | 64'd2, 1'b0);
    chk_cap(1, INIT | 64'd3, 1'b0);
    chk_cap(2, INIT | 64'd4, 1'b0);

    cap_q.delete();
    t0 = cycle;
    for (int i = 5; i < 9; i++) issue(1'b0, BASE + 64'(i * 8), 8'h00, 64'd0);
    chk("b2b_cycles", 64'(cycle - t0), 64'd4);
    repeat (3) step();
    for (int i = 0; i < 4; i++) chk_cap(i, INIT | 64'(i + 5), 1'b0);

    // Reset with a full queue and a pending write, then with one entry and a write.
    bus.i_response_ready = 1'b0;
    issue(1'b0, BASE + 64'h8, 8'h00, 64'd0);
    issue(1'b0, BASE + 64'h10, 8'h00, 64'd0);
    bus.i_request_valid = 1'b1;
    bus.i_write         = 1'b1;
    bus.i_address       = BASE + 64'h20;
    bus.i_strobe        = 8'hFF;
    bus.i_write_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    rst_n               = 1'b0;
    step();
    rst_n               = 1'b1;
    bus.i_request_valid = 1'b0;
    chk("rst_full_valid", 64'(bus.o_response_valid), 64'd0);
    chk("rst_full_ready", 64'(bus.o_request_ready), 64'd1);
    issue(1'b0, BASE + 64'h8, 8'h00, 64'd0);
    bus.i_request_valid = 1'b1;
    bus.i_address       = BASE + 64'h28;
    bus.i_write         = 1'b1;
    rst_n               = 1'b0;
    step();
    rst_n               = 1'b1;
    bus.i_request_valid = 1'b0;
    chk("rst_one_valid", 64'(bus.o_response_valid), 64'd0);
    bus.i_response_ready = 1'b1;
    cap_q.delete();
    issue(1'b0, BASE + 64'h20, 8'h00, 64'd0);
    issue(1'b0, BASE + 64'h28, 8'h00, 64'd0);
    repeat (3) step();
    chk_cap(0, INIT | 64'd4, 1'b0);
    chk_cap(1, INIT | 64'd5, 1'b0);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [63:0] a;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = BASE + 64'($urandom_range(0, WORDS - 1) * 8);
      else if (kind == 7) a = BASE + 64'($urandom_range(0, WORDS - 1) * 8 + $urandom_range(1, 7));
      else if (kind == 8) a = BASE - 64'($urandom_range(1, 4) * 8);
      else                a = BASE + 64'(WORDS * 8) + 64'($urandom_range(0, 3) * 8);
      issue($urandom_range(0, 1) == 1, a, 8'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_ready = 1'b0;
    step();
    bus.i_response_ready = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
